hazard_ctrl: RTL and testbench

Pipeline hazard controller and stall sequencer for the 5-stage core. Each cycle it drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, taken branches, ID-stage jumps and multi-cycle mul/div occupancy of EX. It also keeps a saturating stall-cycle counter for performance analysis.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl_lu_detect.sv | 21 ++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional feature macro: HAZARD_MULDIV_EN (multi-cycle mul/div stall sequencing).
package hazard_pkg;

  // Register-number width of the 32-entry register file.
  localparam int unsigned REG_W = 5;

  // Legal bounds of MD_LAT, the total number of EX cycles a mul/div takes.
  localparam int unsigned MD_LAT_MIN = 2;
  localparam int unsigned MD_LAT_MAX = 15;

  // Width of the mul/div occupancy down-counter. It must hold MD_LAT_MAX-2.
  localparam int unsigned MD_CNT_W = 4;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl.
// master: the hazard controller (drives enables/flushes/status, reads hazard sources).
// slave : the pipeline datapath (drives hazard sources and perf_clr, reads controls).
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import hazard_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_jump;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rt;
  logic             ex_br_taken;
  logic             ex_md_start;
  logic             perf_clr;

  logic             pc_we;
  logic             ifid_we;
  logic             idex_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
    input  ex_memread, ex_rt, ex_br_taken, ex_md_start, perf_clr,
    output pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_flush,
    output md_busy, md_done, stall_cycles
  );

  modport slave (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
    output ex_memread, ex_rt, ex_br_taken, ex_md_start, perf_clr,
    input  pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_flush,
    input  md_busy, md_done, stall_cycles
  );

endinterface

// File: rtl/hazard_ctrl_lu_detect.sv
// lu_detect: combinational load-use comparator.
// Ports: ID source registers and their use flags, EX load flag and its
// destination register; lu is high when the ID instruction needs the load result.
// Register 0 is hard-wired zero and never creates a dependency.
module lu_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  output logic             lu
);

  assign lu = ex_memread && (ex_rt != '0) &&
              ((id_uses_rs && (id_rs == ex_rt)) ||
               (id_uses_rt && (id_rt == ex_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller and stall sequencer for the 5-stage core.
// Ports: clk, reset (async, active-low), hif (hazard_ctrl_if.master) carrying the
// hazard sources, the PC/IF/ID/EX/MEM enables and flushes, mul/div status and the
// saturating stall-cycle counter.
// Control outputs are combinational from state and inputs so stalls act in the
// detection cycle. Optional macro HAZARD_MULDIV_EN adds mul/div EX occupancy sequencing.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.master hif
);

  if ((MD_LAT < MD_LAT_MIN) || (MD_LAT > MD_LAT_MAX)) begin : g_md_lat_bad
    $error("hazard_ctrl: MD_LAT out of legal range");
  end

  logic             lu;
  logic             md_stall;
  logic             pc_we;
  logic             ifid_we;
  logic             idex_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  lu_detect u_lu_detect (
    .id_rs      (hif.id_rs),
    .id_rt      (hif.id_rt),
    .id_uses_rs (hif.id_uses_rs),
    .id_uses_rt (hif.id_uses_rt),
    .ex_memread (hif.ex_memread),
    .ex_rt      (hif.ex_rt),
    .lu         (lu)
  );

`ifdef HAZARD_MULDIV_EN
  hz_state_t           state;
  hz_state_t           state_nxt;
  logic [MD_CNT_W-1:0] md_cnt;
  logic [MD_CNT_W-1:0] md_cnt_nxt;

  // State and occupancy counter register; reset aborts any mul/div sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end
`else
  logic unused_md_start;
  assign unused_md_start = hif.ex_md_start;
`endif

  // Next-state and per-cycle control, in priority order.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    md_stall    = 1'b0;
`ifdef HAZARD_MULDIV_EN
    state_nxt   = state;
    md_cnt_nxt  = md_cnt;

    // ex_md_start stays high while the mul/div is held, so it is only looked at in RUN.
    // A taken branch alongside it is illegal; the branch wins and nothing is loaded.
    unique case (state)
      RUN: begin
        if (hif.ex_md_start) begin
          md_stall = 1'b1;
          if (!hif.ex_br_taken) begin
            state_nxt  = MD_BUSY;
            md_cnt_nxt = MD_CNT_W'(MD_LAT - 2);
          end
        end
      end
      MD_BUSY: begin
        if (md_cnt != '0) begin
          md_stall   = 1'b1;
          md_cnt_nxt = md_cnt - MD_CNT_W'(1);
        end else begin
          md_done   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
`endif

    if (hif.ex_br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (md_stall) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_flush = 1'b1;
      md_busy     = 1'b1;
    end else if (lu) begin
      // One bubble: hold PC and IF/ID, squash the dependent op entering EX.
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end else if (hif.id_jump) begin
      ifid_flush = 1'b1;
    end

    // Hold the whole pipeline frozen and drained while in reset.
    if (!reset) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      md_busy     = 1'b0;
      md_done     = 1'b0;
    end
  end

  // Saturating count of cycles with the PC held; clear beats increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (hif.perf_clr) begin
      stall_cnt <= '0;
    end else if (!pc_we && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign hif.pc_we        = pc_we;
  assign hif.ifid_we      = ifid_we;
  assign hif.idex_we      = idex_we;
  assign hif.ifid_flush   = ifid_flush;
  assign hif.idex_flush   = idex_flush;
  assign hif.exmem_flush  = exmem_flush;
  assign hif.md_busy      = md_busy;
  assign hif.md_done      = md_done;
  assign hif.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MD_LAT=4, CNT_W=4).
// Mul/div sequences are exercised when HAZARD_MULDIV_EN is defined; otherwise the
// bench checks that ex_md_start is ignored.
module tb_hazard_ctrl;

  localparam int unsigned MD_LAT = 4;
  localparam int unsigned CNT_W  = 4;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  int   exp_stall;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_ctrl #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one clock and land just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hif.id_rs       = '0;
    hif.id_rt       = '0;
    hif.id_uses_rs  = 1'b0;
    hif.id_uses_rt  = 1'b0;
    hif.id_jump     = 1'b0;
    hif.ex_memread  = 1'b0;
    hif.ex_rt       = '0;
    hif.ex_br_taken = 1'b0;
    hif.ex_md_start = 1'b0;
    hif.perf_clr    = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc_we"},   32'(hif.pc_we),       32'd0);
    chk({tag, "_ifid_we"}, 32'(hif.ifid_we),     32'd0);
    chk({tag, "_idex_we"}, 32'(hif.idex_we),     32'd0);
    chk({tag, "_ifid_fl"}, 32'(hif.ifid_flush),  32'd1);
    chk({tag, "_idex_fl"}, 32'(hif.idex_flush),  32'd1);
    chk({tag, "_exmem_fl"},32'(hif.exmem_flush), 32'd1);
    chk({tag, "_md_busy"}, 32'(hif.md_busy),     32'd0);
    chk({tag, "_md_done"}, 32'(hif.md_done),     32'd0);
    chk({tag, "_stall"},   32'(hif.stall_cycles),32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    exp_stall = 0;
    reset = 1'b0;
    idle_inputs();

    // Reset state
    #3;
    chk_reset_outputs("rst");
    cyc();
    reset = 1'b1;
    #1;

    // Idle defaults
    chk("idle_pc_we", 32'(hif.pc_we), 32'd1);
    chk("idle_idex_we", 32'(hif.idex_we), 32'd1);
    chk("idle_ifid_fl", 32'(hif.ifid_flush), 32'd0);
    chk("idle_exmem_fl", 32'(hif.exmem_flush), 32'd0);
    cyc();

    // Load-use on rs: one bubble, counter 0 -> 1, then defaults
    hif.ex_memread = 1'b1; hif.ex_rt = 5'd5; hif.id_rs = 5'd5; hif.id_uses_rs = 1'b1;
    #1;
    chk("lu_rs_pc_we", 32'(hif.pc_we), 32'd0);
    chk("lu_rs_ifid_we", 32'(hif.ifid_we), 32'd0);
    chk("lu_rs_idex_fl", 32'(hif.idex_flush), 32'd1);
    chk("lu_rs_idex_we", 32'(hif.idex_we), 32'd1);
    chk("lu_rs_stall0", 32'(hif.stall_cycles), 32'd0);
    cyc();
    exp_stall = 1;
    hif.ex_memread = 1'b0;
    #1;
    chk("lu_rs_stall1", 32'(hif.stall_cycles), 32'(exp_stall));
    chk("lu_rs_after_pc_we", 32'(hif.pc_we), 32'd1);
    chk("lu_rs_after_idex_fl", 32'(hif.idex_flush), 32'd0);
    cyc();

    // Load-use on rt; rt match without id_uses_rt must not stall
    idle_inputs();
    hif.ex_memread = 1'b1; hif.ex_rt = 5'd7; hif.id_rt = 5'd7; hif.id_uses_rt = 1'b1;
    hif.id_rs = 5'd3; hif.id_uses_rs = 1'b1;
    #1;
    chk("lu_rt_pc_we", 32'(hif.pc_we), 32'd0);
    cyc();
    exp_stall++;
    hif.id_uses_rt = 1'b0;
    #1;
    chk("lu_rt_unused_pc_we", 32'(hif.pc_we), 32'd1);
    chk("lu_rt_stall", 32'(hif.stall_cycles), 32'(exp_stall));
    cyc();

    // ex_rt = 0 never hazards
    idle_inputs();
    hif.ex_memread = 1'b1; hif.ex_rt = 5'd0; hif.id_rs = 5'd0; hif.id_uses_rs = 1'b1;
    #1;
    chk("r0_pc_we", 32'(hif.pc_we), 32'd1);
    chk("r0_idex_fl", 32'(hif.idex_flush), 32'd0);
    cyc();
    chk("r0_stall", 32'(hif.stall_cycles), 32'(exp_stall));

    // Branch beats load-use and jump
    idle_inputs();
    hif.ex_memread = 1'b1; hif.ex_rt = 5'd9; hif.id_rs = 5'd9; hif.id_uses_rs = 1'b1;
    hif.id_jump = 1'b1; hif.ex_br_taken = 1'b1;
    #1;
    chk("br_pc_we", 32'(hif.pc_we), 32'd1);
    chk("br_ifid_fl", 32'(hif.ifid_flush), 32'd1);
    chk("br_idex_fl", 32'(hif.idex_flush), 32'd1);
    chk("br_exmem_fl", 32'(hif.exmem_flush), 32'd0);
    cyc();
    chk("br_stall", 32'(hif.stall_cycles), 32'(exp_stall));

    // Load-use beats jump; jump seen alone next cycle
    hif.ex_br_taken = 1'b0;
    #1;
    chk("lujmp_pc_we", 32'(hif.pc_we), 32'd0);
    chk("lujmp_ifid_fl", 32'(hif.ifid_flush), 32'd0);
    chk("lujmp_idex_fl", 32'(hif.idex_flush), 32'd1);
    cyc();
    exp_stall++;
    hif.ex_memread = 1'b0;
    #1;
    chk("jmp_pc_we", 32'(hif.pc_we), 32'd1);
    chk("jmp_ifid_fl", 32'(hif.ifid_flush), 32'd1);
    chk("jmp_idex_fl", 32'(hif.idex_flush), 32'd0);
    chk("jmp_stall", 32'(hif.stall_cycles), 32'(exp_stall));
    cyc();
    idle_inputs();

`ifdef HAZARD_MULDIV_EN
    // Mul/div held in EX: stall T..T+2, md_done at T+3
    hif.ex_md_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("md_busy_c%0d", i), 32'(hif.md_busy), 32'd1);
      chk($sformatf("md_pc_we_c%0d", i), 32'(hif.pc_we), 32'd0);
      chk($sformatf("md_idex_we_c%0d", i), 32'(hif.idex_we), 32'd0);
      chk($sformatf("md_exmem_fl_c%0d", i), 32'(hif.exmem_flush), 32'd1);
      chk($sformatf("md_done_c%0d", i), 32'(hif.md_done), 32'd0);
      cyc();
      exp_stall++;
    end
    #1;
    chk("md_done_t3", 32'(hif.md_done), 32'd1);
    chk("md_busy_t3", 32'(hif.md_busy), 32'd0);
    chk("md_pc_we_t3", 32'(hif.pc_we), 32'd1);
    chk("md_stall_cnt", 32'(hif.stall_cycles), 32'(exp_stall));
    cyc();
    hif.ex_md_start = 1'b0;
    #1;
    chk("md_run_done", 32'(hif.md_done), 32'd0);
    chk("md_run_pc_we", 32'(hif.pc_we), 32'd1);

    // Branch with md_start: branch wins, no sequence starts
    hif.ex_md_start = 1'b1; hif.ex_br_taken = 1'b1;
    #1;
    chk("mdbr_pc_we", 32'(hif.pc_we), 32'd1);
    chk("mdbr_busy", 32'(hif.md_busy), 32'd0);
    cyc();
    idle_inputs();
    #1;
    chk("mdbr_after_busy", 32'(hif.md_busy), 32'd0);
    chk("mdbr_after_done", 32'(hif.md_done), 32'd0);
    chk("mdbr_stall", 32'(hif.stall_cycles), 32'(exp_stall));

    // Reset two cycles into MD_BUSY aborts; full restart afterwards
    hif.ex_md_start = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk_reset_outputs("mdrst");
    cyc();
    reset = 1'b1;
    exp_stall = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mdre_busy_c%0d", i), 32'(hif.md_busy), 32'd1);
      chk($sformatf("mdre_pc_we_c%0d", i), 32'(hif.pc_we), 32'd0);
      cyc();
      exp_stall++;
    end
    #1;
    chk("mdre_done", 32'(hif.md_done), 32'd1);
    chk("mdre_stall", 32'(hif.stall_cycles), 32'(exp_stall));
    cyc();
    idle_inputs();
`else
    // Mul/div support absent: ex_md_start has no effect
    hif.ex_md_start = 1'b1;
    #1;
    chk("nomd_pc_we", 32'(hif.pc_we), 32'd1);
    chk("nomd_busy", 32'(hif.md_busy), 32'd0);
    chk("nomd_exmem_fl", 32'(hif.exmem_flush), 32'd0);
    cyc();
    chk("nomd_done", 32'(hif.md_done), 32'd0);
    chk("nomd_stall", 32'(hif.stall_cycles), 32'(exp_stall));
    idle_inputs();
`endif

    // Saturation at 15, then perf_clr beats the increment
    hif.ex_memread = 1'b1; hif.ex_rt = 5'd12; hif.id_rt = 5'd12; hif.id_uses_rt = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_15", 32'(hif.stall_cycles), 32'd15);
    cyc();
    chk("sat_hold", 32'(hif.stall_cycles), 32'd15);
    hif.perf_clr = 1'b1;
    cyc();
    chk("clr_0", 32'(hif.stall_cycles), 32'd0);
    hif.perf_clr = 1'b0;
    cyc();
    chk("clr_then_1", 32'(hif.stall_cycles), 32'd1);
    idle_inputs();
    cyc();
    chk("final_pc_we", 32'(hif.pc_we), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
